// File: rtl/csa_acc_resolve_pkg.sv
// csa_acc_pkg: shared state enum and width-derivation helpers for csa_acc_resolve.
package csa_acc_pkg;

    typedef enum logic [1:0] {ST_ACC, ST_RESOLVE, ST_OUT} state_e;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int num_chunks(input int aw, input int chunk);
        return (aw + chunk - 1) / chunk;
    endfunction

    function automatic int cnt_width(input int maxb);
        return clog2(maxb + 1);
    endfunction

    function automatic int idx_width(input int nch);
        return nch > 1 ? clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/csa_acc_resolve_4to2.sv
// csa_4to2: AW-bit 4:2 carry-save compressor built from two layers of full adders.
// Ports: a_i/b_i/c_i/d_i AW-bit addends; s_o/c_o redundant result (c_o already weight-aligned).
// Carries leaving bit AW-1 are dropped, so the result is exact modulo 2^AW.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module csa_4to2
    import csa_acc_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    input  logic [AW-1:0] c_i,
    input  logic [AW-1:0] d_i,
    output logic [AW-1:0] s_o,
    output logic [AW-1:0] c_o
);
    logic [AW-1:0] s1, co1, c1, s2, co2;
    logic          unused_msb;

    genvar i;
    generate
        for (i = 0; i < AW; i++) begin : g_bit
            full_adder u_l1 (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c_i[i]), .s_o(s1[i]), .co_o(co1[i]));
            full_adder u_l2 (.a_i(s1[i]), .b_i(c1[i]), .c_i(d_i[i]), .s_o(s2[i]), .co_o(co2[i]));
        end
    endgenerate

    assign c1         = {co1[AW-2:0], 1'b0};
    assign s_o        = s2;
    assign c_o        = {co2[AW-2:0], 1'b0};
    assign unused_msb = co1[AW-1] ^ co2[AW-1];

endmodule

// File: rtl/csa_acc_resolve.sv
// csa_acc_resolve: carry-save frame accumulator with chunked multi-cycle resolve to binary.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_sum/in_carry/in_last beat stream;
//        out_valid/out_ready/out_data/out_sat/out_err frame result.
// Config: define CSA_ACC_SAT_EN to saturate out_data at 2^OW-1 and report out_sat; otherwise
//         out_data wraps modulo 2^OW and out_sat stays 0.
module csa_acc_resolve
    import csa_acc_pkg::*;
#(
    parameter int IW    = 7,
    parameter int MAXB  = 8,
    parameter int AW    = 11,
    parameter int CHUNK = 4,
    parameter int OW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_sum,
    input  logic [IW-1:0] in_carry,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_sat,
    output logic          out_err
);
    localparam int NCH = num_chunks(AW, CHUNK);
    localparam int CW  = cnt_width(MAXB);
    localparam int XW  = idx_width(NCH);
    localparam int RW  = NCH * CHUNK;

    state_e        state_q;
    logic [AW-1:0] acc_s_q, acc_c_q, csa_s, csa_c;
    logic [CW-1:0] cnt_q;
    logic [XW-1:0] idx_q;
    logic          cin_q;
    logic [RW-1:0] res_q, res_d, s_ext, c_ext;
    logic [CHUNK:0] ch_sum;
    logic [AW-1:0] total;
    logic          ovf, sat_d;
    logic [OW-1:0] data_d;
    logic          in_ready_q, out_valid_q, out_sat_q, out_err_q;
    logic [OW-1:0] out_data_q;
    logic          accept, last_beat;

    assign accept    = in_valid & in_ready_q;
    assign last_beat = in_last | (cnt_q == CW'(MAXB - 1));

    csa_4to2 #(.AW(AW)) u_csa (
        .a_i(acc_s_q),
        .b_i(acc_c_q),
        .c_i(AW'(in_sum)),
        .d_i(AW'(in_carry)),
        .s_o(csa_s),
        .c_o(csa_c)
    );

    // Padded copies let the final chunk read past AW without special-casing a short chunk.
    always_comb begin
        s_ext  = RW'(acc_s_q);
        c_ext  = RW'(acc_c_q);
        ch_sum = {1'b0, s_ext[int'(idx_q)*CHUNK +: CHUNK]} + {1'b0, c_ext[int'(idx_q)*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cin_q};
        res_d  = res_q;
        res_d[int'(idx_q)*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
        total  = res_d[AW-1:0];
        ovf    = (total >> OW) != '0;
    end

`ifdef CSA_ACC_SAT_EN
    assign sat_d  = ovf;
    assign data_d = ovf ? '1 : OW'(total);
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign sat_d      = 1'b0;
    assign data_d     = OW'(total);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            cin_q       <= 1'b0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: if (accept) begin
                    acc_s_q <= csa_s;
                    acc_c_q <= csa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_beat) begin
                        state_q    <= ST_RESOLVE;
                        in_ready_q <= 1'b0;
                        idx_q      <= '0;
                        cin_q      <= 1'b0;
                        out_err_q  <= ~in_last;
                    end
                end
                ST_RESOLVE: begin
                    res_q <= res_d;
                    cin_q <= ch_sum[CHUNK];
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == XW'(NCH - 1)) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= data_d;
                        out_sat_q   <= sat_d;
                    end
                end
                ST_OUT: if (out_ready) begin
                    state_q     <= ST_ACC;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    acc_s_q     <= '0;
                    acc_c_q     <= '0;
                    cnt_q       <= '0;
                    idx_q       <= '0;
                    cin_q       <= 1'b0;
                    out_data_q  <= '0;
                    out_sat_q   <= 1'b0;
                    out_err_q   <= 1'b0;
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_csa_acc_resolve.sv
// tb_csa_acc_resolve: directed self-checking bench for csa_acc_resolve (default parameters).
module tb_csa_acc_resolve;
    logic       clk, rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_sat, out_err;
    logic [6:0] in_sum, in_carry;
    logic [7:0] out_data;
    int         n_chk = 0;
    int         n_pass = 0;

    csa_acc_resolve u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Called at a negedge; presents one beat, waits (bounded) for in_ready, returns at the negedge after acceptance.
    task automatic beat(input logic [6:0] s, input logic [6:0] c, input logic l);
        int n = 0;
        in_sum = s; in_carry = c; in_last = l; in_valid = 1'b1;
        while (!in_ready && n < 30) begin @(negedge clk); n++; end
        if (n >= 30) chk("beat_ready_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        while (!out_valid && n < 30) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_sat"}, out_sat, s);
        chk({tag, "_err"}, out_err, e);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_sum = '0; in_carry = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_out_err", out_err, 0);

        beat(7'd5, 7'd3, 1'b1);
        lat = 0;
        while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
        chk("single_latency", lat, 3);
        take("single", 8'd8, 1'b0, 1'b0);

        beat(7'd10, 7'd4, 1'b0);
        beat(7'd127, 7'd127, 1'b0);
        beat(7'd0, 7'd1, 1'b1);
`ifdef CSA_ACC_SAT_EN
        take("three", 8'd255, 1'b1, 1'b0);
`else
        take("three", 8'd13, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 8; i++) beat(7'd127, 7'd127, 1'b0);
        in_sum = 7'd1; in_carry = 7'd0; in_last = 1'b1; in_valid = 1'b1;
        chk("forced_holdoff_ready", in_ready, 0);
`ifdef CSA_ACC_SAT_EN
        take("forced", 8'd255, 1'b1, 1'b1);
`else
        take("forced", 8'd240, 1'b0, 1'b1);
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        take("ninth", 8'd1, 1'b0, 1'b0);

        beat(7'd1, 7'd1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 2);
            chk("stall_ready", in_ready, 0);
            @(negedge clk);
        end
        take("stall", 8'd2, 1'b0, 1'b0);

        beat(7'd50, 7'd50, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        chk("abort_err", out_err, 0);
        chk("abort_sat", out_sat, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", in_ready, 1);
        repeat (4) @(negedge clk);
        chk("abort_no_output", out_valid, 0);
        beat(7'd3, 7'd4, 1'b1);
        take("after_abort", 8'd7, 1'b0, 1'b0);

        in_sum = 7'd2; in_carry = 7'd2; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_sum = 7'd9; in_carry = 7'd0;
        take("b2b_first", 8'd4, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        take("b2b_second", 8'd9, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        chk("b2b_no_dup", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/csa_acc_resolve.md
# csa_acc_resolve

Sequential consumer for the carry-save adder tree. It accepts a stream of redundant (sum, carry) vector pairs from the tree output and accumulates them over a frame, keeping the running total in carry-save form. At frame end it resolves the total to binary with a chunked multi-cycle carry-propagate adder. It sits between the CNN partial-product compressor tree and the activation/writeback stage.

## Interface
- IW, default 7: width of each incoming sum/carry vector.
- MAXB, default 8: maximum number of beats per frame.
- AW, default 11: accumulator width; must be ≥ IW+1+clog2(MAXB).
- CHUNK, default 4: bits resolved per cycle.
- OW, default 8: output result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_sum  in  IW  sum vector from the tree.
- in_carry  in  IW  carry vector from the tree, already bit-aligned to weight.
- in_last  in  1  final beat of the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_data  out  OW  resolved frame total.
- out_sat  out  1  total exceeded 2^OW−1 (see Configuration).
- out_err  out  1  frame was force-terminated at MAXB beats.

## Operation
- States: ACC, RESOLVE, OUT.
- ACC:
  - in_ready=1.
  - Each accepted beat compresses {acc_s, acc_c, in_sum, in_carry} through a 4:2 compressor (two 3:2 layers). Inputs are zero-extended to AW; carry outputs shift left by 1; bits above AW are dropped.
  - The beat counter increments on each accepted beat.
  - If an accepted beat has in_last=1, or is the MAXB-th beat, go to RESOLVE.
  - out_err is set only when the MAXB-th beat arrives with in_last=0. Beats after a forced termination start a new frame.
- RESOLVE:
  - in_ready=0.
  - The chunk index runs 0..NCH−1, where NCH=ceil(AW/CHUNK).
  - Each cycle adds acc_s and acc_c bits [idx*CHUNK +: CHUNK] with a registered carry-in (0 for chunk 0) and writes the result bits.
  - After chunk NCH−1, go to OUT.
- OUT:
  - out_valid=1; out_data, out_sat and out_err are held stable until the handshake.
  - On the handshake, clear the accumulator, counter, carry and flags, then go to ACC.
  - Handshake and a new beat never coincide: in_ready is 0 in OUT, so the first beat of the next frame is accepted at the earliest one cycle after the output handshake.
- A frame with zero beats is impossible; no output is produced without at least one beat.

## Timing
- Reset values: state ACC, in_ready=1 once rst_n deasserts, out_valid=0, out_data=0, out_sat=0, out_err=0, accumulator 0.
- Reset asserted in any state aborts the frame immediately; the partial result is discarded.
- Throughput in ACC: one beat per cycle.
- Latency: with the last beat accepted at edge E, out_valid is 1 after edge E+NCH (default 3 edges).
- Minimum frame period: beats + NCH + 1 cycles.
- in_sum and in_carry are sampled only at the handshake edge.

## Configuration
- CSA_ACC_SAT_EN defined:
  - If the resolved AW-bit total is > 2^OW−1, out_data is all-ones and out_sat=1.
  - Otherwise out_data is the total and out_sat=0.
- CSA_ACC_SAT_EN undefined:
  - out_data is the low OW bits of the total (modulo 2^OW).
  - out_sat is tied 0.

## Structure
- Package csa_acc_pkg holds:
  - the state enum (ACC, RESOLVE, OUT);
  - a clog2 function;
  - the NCH and beat-counter-width derivation helpers.
- One sub-module, csa_4to2, implements the combinational AW-bit 4:2 compressor with full_adder cells. The top module holds all registers and the FSM.

## Test plan
- Single beat (5,3) with in_last=1 → out_data=8, out_sat=0, out_err=0; out_valid rises 3 edges after acceptance.
- Three beats (10,4), (127,127), (0,1) with last on beat 3 → total 269. With SAT_EN: out_data=255, out_sat=1. Without: out_data=13, out_sat=0.
- Eight beats of (127,127) with in_last=0 throughout → forced termination; total 2032, out_err=1. The ninth beat is held off until OUT completes, then starts a new frame.
- Beat (1,1) last, then out_ready held low for 5 cycles:
  - out_valid, out_data=2 and in_ready=0 stay stable throughout.
  - On release, in_ready=1 on the cycle after the handshake.
- rst_n pulsed low during RESOLVE of a frame totalling 100 → all outputs return to reset values. A subsequent frame (3,4) last → out_data=7 with no residue from the aborted frame.
- Back-to-back frames with in_valid held high: (2,2) last, then (9,0) last → outputs 4 then 9, with no beat dropped or duplicated.
